// File: rtl/uart_debug_host_if.sv
// uart_debug_host_if
//   Bundles every non-clock/reset signal of uart_debug_host. Member names are
//   the host's port names, so i_* are host inputs and o_* are host outputs.
//   master : the host side (uart_debug_host)
//   slave  : the environment side (command source, UART pair, program ROM,
//            dump consumer)
//   Groups: command handshake (i_cmd_valid, i_cmd, o_busy, o_cmd_done,
//           o_cmd_error, o_timeout, o_echo_error), UART (o_tx_start,
//           o_tx_data, i_tx_done, i_rx_done, i_rx_data), ROM (o_prog_addr,
//           i_prog_data), dump stream (o_dump_valid, o_dump_data,
//           o_dump_section, o_dump_index, o_dump_end, o_mem_bytes).
interface uart_debug_host_if #(
  parameter int NB_PROG_ADDR = 8
);
  logic                    i_cmd_valid;
  logic [2:0]              i_cmd;
  logic                    o_busy;
  logic                    o_cmd_done;
  logic                    o_cmd_error;
  logic                    o_timeout;
  logic                    o_echo_error;
  logic                    o_tx_start;
  logic [7:0]              o_tx_data;
  logic                    i_tx_done;
  logic                    i_rx_done;
  logic [7:0]              i_rx_data;
  logic [NB_PROG_ADDR-1:0] o_prog_addr;
  logic [31:0]             i_prog_data;
  logic                    o_dump_valid;
  logic [7:0]              o_dump_data;
  logic [1:0]              o_dump_section;
  logic [7:0]              o_dump_index;
  logic                    o_dump_end;
  logic [15:0]             o_mem_bytes;

  modport master (
    input  i_cmd_valid, i_cmd, i_tx_done, i_rx_done, i_rx_data, i_prog_data,
    output o_busy, o_cmd_done, o_cmd_error, o_timeout, o_echo_error,
           o_tx_start, o_tx_data, o_prog_addr, o_dump_valid, o_dump_data,
           o_dump_section, o_dump_index, o_dump_end, o_mem_bytes
  );

  modport slave (
    output i_cmd_valid, i_cmd, i_tx_done, i_rx_done, i_rx_data, i_prog_data,
    input  o_busy, o_cmd_done, o_cmd_error, o_timeout, o_echo_error,
           o_tx_start, o_tx_data, o_prog_addr, o_dump_valid, o_dump_data,
           o_dump_section, o_dump_index, o_dump_end, o_mem_bytes
  );
endinterface

// File: rtl/uart_debug_host.sv
// uart_debug_host
//   Host-side initiator of the pipeline UART debug link. Sends load / run /
//   debug / step / end-debug commands, checks every byte against its echo,
//   streams program ROM words during a load and forwards the register,
//   latch and memory dump that follows run and step.
//   Ports:
//     i_clk, i_reset : clock and synchronous active-high reset
//     bus            : uart_debug_host_if.master (command handshake, UART
//                      tx/rx, program ROM, tagged dump stream)
//   Parameters: NB_PROG_ADDR (ROM word address width), NB_IF_ID / NB_ID_EX /
//   NB_EX_MEM / NB_MEM_WB (device latch widths), TIMEOUT_CYCLES (idle cycles
//   that end a wait; must exceed one byte time).
module uart_debug_host #(
  parameter int NB_PROG_ADDR   = 8,
  parameter int NB_IF_ID       = 64,
  parameter int NB_ID_EX       = 168,
  parameter int NB_EX_MEM      = 88,
  parameter int NB_MEM_WB      = 80,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic               i_clk,
  input logic               i_reset,
  uart_debug_host_if.master bus
);

  localparam int REG_BYTES   = 128;
  localparam int LATCH_BYTES = (NB_IF_ID + NB_ID_EX + NB_EX_MEM + NB_MEM_WB + 7) / 8;
  localparam int FIXED_BYTES = REG_BYTES + LATCH_BYTES;
  localparam int FW          = $clog2(FIXED_BYTES);
  localparam int TW          = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [NB_PROG_ADDR-1:0] LAST_ADDR = '1;
  localparam logic [2:0] CMD_LOAD  = 3'd0;
  localparam logic [2:0] CMD_RUN   = 3'd1;
  localparam logic [2:0] CMD_DEBUG = 3'd2;
  localparam logic [2:0] CMD_STEP  = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT_TXDONE, S_WAIT_ECHO, S_FETCH, S_DUMP_FIXED, S_DUMP_MEM
  } state_t;

  state_t                  state_reg;
  logic                    debug_mode_reg;
  logic [2:0]              cmd_reg;
  logic                    opcode_phase_reg;   // byte in flight is the opcode
  logic [31:0]             word_reg;           // remaining bytes of the word, MSB aligned
  logic [1:0]              byte_cnt_reg;       // index of the word byte in flight
  logic                    last_word_reg;      // word in flight ends the load
  logic                    word_at_end_reg;    // word in flight came from LAST_ADDR
  logic [NB_PROG_ADDR-1:0] prog_addr_reg;
  logic [TW-1:0]           timer_reg;
  logic [FW-1:0]           fixed_cnt_reg;
  logic                    end_pending_reg;

  logic        busy_reg, cmd_done_reg, cmd_error_reg, timeout_reg, echo_error_reg;
  logic        tx_start_reg, dump_valid_reg, dump_end_reg;
  logic [7:0]  tx_data_reg, dump_data_reg, dump_index_reg;
  logic [1:0]  dump_section_reg;
  logic [15:0] mem_bytes_reg;

  logic cmd_ok;
  logic timer_expired;

  // Load/run/debug need IDLE mode, step/end need DEBUG mode, 5-7 never pass.
  assign cmd_ok = (bus.i_cmd <= CMD_DEBUG) ? !debug_mode_reg :
                  (bus.i_cmd <= 3'd4)      ?  debug_mode_reg : 1'b0;
  assign timer_expired = (timer_reg == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg        <= S_IDLE;
      debug_mode_reg   <= 1'b0;
      cmd_reg          <= '0;
      opcode_phase_reg <= 1'b0;
      word_reg         <= '0;
      byte_cnt_reg     <= '0;
      last_word_reg    <= 1'b0;
      word_at_end_reg  <= 1'b0;
      prog_addr_reg    <= '0;
      timer_reg        <= '0;
      fixed_cnt_reg    <= '0;
      end_pending_reg  <= 1'b0;
      busy_reg         <= 1'b0;
      cmd_done_reg     <= 1'b0;
      cmd_error_reg    <= 1'b0;
      timeout_reg      <= 1'b0;
      echo_error_reg   <= 1'b0;
      tx_start_reg     <= 1'b0;
      tx_data_reg      <= '0;
      dump_valid_reg   <= 1'b0;
      dump_data_reg    <= '0;
      dump_section_reg <= '0;
      dump_index_reg   <= '0;
      dump_end_reg     <= 1'b0;
      mem_bytes_reg    <= '0;
    end else begin
      tx_start_reg   <= 1'b0;
      cmd_done_reg   <= 1'b0;
      cmd_error_reg  <= 1'b0;
      timeout_reg    <= 1'b0;
      dump_valid_reg <= 1'b0;
      dump_end_reg   <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (bus.i_cmd_valid) begin
            if (cmd_ok) begin
              busy_reg         <= 1'b1;
              cmd_reg          <= bus.i_cmd;
              opcode_phase_reg <= 1'b1;
              last_word_reg    <= 1'b0;
              prog_addr_reg    <= '0;
              tx_data_reg      <= {5'd0, bus.i_cmd};
              tx_start_reg     <= 1'b1;
              state_reg        <= S_SEND;
            end else begin
              cmd_error_reg <= 1'b1;
            end
          end
        end

        // o_tx_start is high during this cycle.
        S_SEND: begin
          timer_reg <= '0;
          state_reg <= S_WAIT_TXDONE;
        end

        S_WAIT_TXDONE: begin
          if (bus.i_tx_done) begin
            timer_reg <= '0;
            state_reg <= S_WAIT_ECHO;
          end else if (timer_expired) begin
            timeout_reg <= 1'b1;
            busy_reg    <= 1'b0;
            state_reg   <= S_IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        S_WAIT_ECHO: begin
          if (bus.i_rx_done) begin
            if (bus.i_rx_data != tx_data_reg) echo_error_reg <= 1'b1;
            timer_reg <= '0;
            if (opcode_phase_reg) begin
              opcode_phase_reg <= 1'b0;
              case (cmd_reg)
                CMD_LOAD: state_reg <= S_FETCH;
                CMD_RUN, CMD_STEP: begin
                  fixed_cnt_reg <= '0;
                  state_reg     <= S_DUMP_FIXED;
                end
                CMD_DEBUG: begin
                  debug_mode_reg <= 1'b1;
                  cmd_done_reg   <= 1'b1;
                  busy_reg       <= 1'b0;
                  state_reg      <= S_IDLE;
                end
                default: begin
                  debug_mode_reg <= 1'b0;
                  cmd_done_reg   <= 1'b1;
                  busy_reg       <= 1'b0;
                  state_reg      <= S_IDLE;
                end
              endcase
            end else if (byte_cnt_reg != 2'd3) begin
              // The next word's address is presented while the last byte of
              // this word is still in flight, so the ROM has settled well
              // before FETCH samples it. The address never wraps.
              if (byte_cnt_reg == 2'd2 && prog_addr_reg != LAST_ADDR)
                prog_addr_reg <= prog_addr_reg + 1'b1;
              byte_cnt_reg <= byte_cnt_reg + 1'b1;
              tx_data_reg  <= word_reg[31:24];
              word_reg     <= {word_reg[23:0], 8'h00};
              tx_start_reg <= 1'b1;
              state_reg    <= S_SEND;
            end else if (last_word_reg) begin
              cmd_done_reg <= 1'b1;
              busy_reg     <= 1'b0;
              state_reg    <= S_IDLE;
            end else if (word_at_end_reg) begin
              // ROM exhausted without a halt word: append one.
              last_word_reg <= 1'b1;
              byte_cnt_reg  <= 2'd0;
              tx_data_reg   <= 8'hFF;
              word_reg      <= 32'hFFFF_FF00;
              tx_start_reg  <= 1'b1;
              state_reg     <= S_SEND;
            end else begin
              state_reg <= S_FETCH;
            end
          end else if (timer_expired) begin
            timeout_reg <= 1'b1;
            busy_reg    <= 1'b0;
            state_reg   <= S_IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        S_FETCH: begin
          word_at_end_reg <= (prog_addr_reg == LAST_ADDR);
          last_word_reg   <= (bus.i_prog_data == 32'hFFFF_FFFF);
          byte_cnt_reg    <= 2'd0;
          tx_data_reg     <= bus.i_prog_data[31:24];
          word_reg        <= {bus.i_prog_data[23:0], 8'h00};
          tx_start_reg    <= 1'b1;
          state_reg       <= S_SEND;
        end

        S_DUMP_FIXED: begin
          if (bus.i_rx_done) begin
            timer_reg      <= '0;
            dump_valid_reg <= 1'b1;
            dump_data_reg  <= bus.i_rx_data;
            if (fixed_cnt_reg < FW'(REG_BYTES)) begin
              dump_section_reg <= 2'd0;
              dump_index_reg   <= 8'(fixed_cnt_reg);
            end else begin
              dump_section_reg <= 2'd1;
              dump_index_reg   <= 8'(fixed_cnt_reg - FW'(REG_BYTES));
            end
            if (fixed_cnt_reg == FW'(FIXED_BYTES - 1)) begin
              mem_bytes_reg   <= '0;
              end_pending_reg <= 1'b0;
              state_reg       <= S_DUMP_MEM;
            end else begin
              fixed_cnt_reg <= fixed_cnt_reg + 1'b1;
            end
          end else if (timer_expired) begin
            timeout_reg <= 1'b1;
            busy_reg    <= 1'b0;
            state_reg   <= S_IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        // Memory section length is unknown; silence ends it.
        S_DUMP_MEM: begin
          if (end_pending_reg) begin
            end_pending_reg <= 1'b0;
            cmd_done_reg    <= 1'b1;
            busy_reg        <= 1'b0;
            state_reg       <= S_IDLE;
          end else if (bus.i_rx_done) begin
            timer_reg        <= '0;
            dump_valid_reg   <= 1'b1;
            dump_data_reg    <= bus.i_rx_data;
            dump_section_reg <= 2'd2;
            dump_index_reg   <= (mem_bytes_reg > 16'd255) ? 8'hFF : mem_bytes_reg[7:0];
            if (mem_bytes_reg != 16'hFFFF) mem_bytes_reg <= mem_bytes_reg + 1'b1;
          end else if (timer_expired) begin
            dump_end_reg    <= 1'b1;
            end_pending_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.o_busy         = busy_reg;
  assign bus.o_cmd_done     = cmd_done_reg;
  assign bus.o_cmd_error    = cmd_error_reg;
  assign bus.o_timeout      = timeout_reg;
  assign bus.o_echo_error   = echo_error_reg;
  assign bus.o_tx_start     = tx_start_reg;
  assign bus.o_tx_data      = tx_data_reg;
  assign bus.o_prog_addr    = prog_addr_reg;
  assign bus.o_dump_valid   = dump_valid_reg;
  assign bus.o_dump_data    = dump_data_reg;
  assign bus.o_dump_section = dump_section_reg;
  assign bus.o_dump_index   = dump_index_reg;
  assign bus.o_dump_end     = dump_end_reg;
  assign bus.o_mem_bytes    = mem_bytes_reg;

endmodule

// File: tb/tb_uart_debug_host.sv
// tb_uart_debug_host
//   Self-checking bench for uart_debug_host. A device model echoes each
//   transmitted byte and produces dumps; stimulus pushes expected tx bytes,
//   dump bytes and completion events into queues; a monitor pops and
//   compares whenever the DUT presents them.
module tb_uart_debug_host;
  localparam int AW  = 2;
  localparam int TMO = 300;
  localparam int EV_DONE = 1, EV_ERR = 2, EV_TMO = 3, EV_DEND = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_debug_host_if #(.NB_PROG_ADDR(AW)) bus ();

  uart_debug_host #(
    .NB_PROG_ADDR(AW), .NB_IF_ID(64), .NB_ID_EX(168), .NB_EX_MEM(88),
    .NB_MEM_WB(80), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_tx[$];
  logic [17:0] exp_dump[$];   // {section, index, data}
  int exp_evt[$];
  int exp_mem[$];
  int sec0_seen = 0;

  logic model_debug = 1'b0;
  logic model_echo_err = 1'b0;
  logic [31:0] rom [4];

  logic dev_dump_pending = 1'b0;
  logic [7:0] dev_dump[$];
  int dev_echo_mode = 0;   // 0 echo, 1 corrupt to 0x05, 2 silent
  logic dev_abort = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm, input longint act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got 0x%0h expected nothing at %0t", nm, act, $time);
  endtask

  function automatic logic [63:0] all_outs();
    return {12'd0, bus.o_busy, bus.o_cmd_done, bus.o_cmd_error, bus.o_timeout,
            bus.o_echo_error, bus.o_tx_start, bus.o_tx_data, bus.o_prog_addr,
            bus.o_dump_valid, bus.o_dump_data, bus.o_dump_section,
            bus.o_dump_index, bus.o_dump_end, bus.o_mem_bytes};
  endfunction

  // ROM: data follows the presented address.
  initial begin
    bus.i_prog_data = '0;
    forever begin
      @(posedge clk); #1;
      bus.i_prog_data = rom[bus.o_prog_addr];
    end
  end

  // Device model
  task automatic dev_wait(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.i_tx_done = 1'b0;
      bus.i_rx_done = 1'b0;
    end
  endtask

  task automatic dev_byte(input logic [7:0] b);
    dev_wait($urandom_range(1, 5));
    if (dev_abort) return;
    bus.i_tx_done = 1'b1;
    dev_wait($urandom_range(1, 4));
    if (dev_abort) return;
    if (dev_echo_mode == 2) begin
      dev_echo_mode = 0;
      return;
    end
    bus.i_rx_data = (dev_echo_mode == 1) ? 8'h05 : b;
    dev_echo_mode = 0;
    bus.i_rx_done = 1'b1;
    if (dev_dump_pending) begin
      dev_dump_pending = 1'b0;
      while (dev_dump.size() > 0 && !dev_abort) begin
        dev_wait($urandom_range(1, 6));
        if (!dev_abort) begin
          bus.i_rx_data = dev_dump.pop_front();
          bus.i_rx_done = 1'b1;
        end
      end
      dev_dump.delete();
    end
  endtask

  initial begin
    bus.i_tx_done = 1'b0;
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = '0;
    forever begin
      @(posedge clk); #1;
      bus.i_tx_done = 1'b0;
      bus.i_rx_done = 1'b0;
      if (bus.o_tx_start && !rst && !dev_abort) dev_byte(bus.o_tx_data);
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [17:0] d;
    forever begin
      @(posedge clk); #1;
      if (bus.o_tx_start) begin
        if (exp_tx.size() == 0) unexpected("tx_byte", bus.o_tx_data);
        else chk("tx_byte", bus.o_tx_data, exp_tx.pop_front());
      end
      if (bus.o_dump_valid) begin
        d = {bus.o_dump_section, bus.o_dump_index, bus.o_dump_data};
        if (bus.o_dump_section == 2'd0) sec0_seen++;
        if (exp_dump.size() == 0) unexpected("dump_sec_idx_data", d);
        else chk("dump_sec_idx_data", d, exp_dump.pop_front());
      end
      if (bus.o_dump_end) begin
        if (exp_evt.size() == 0) unexpected("event_dump_end", EV_DEND);
        else chk("event", EV_DEND, exp_evt.pop_front());
        if (exp_mem.size() == 0) unexpected("mem_bytes", bus.o_mem_bytes);
        else chk("mem_bytes", bus.o_mem_bytes, exp_mem.pop_front());
      end
      if (bus.o_cmd_done) begin
        if (exp_evt.size() == 0) unexpected("event_done", EV_DONE);
        else chk("event", EV_DONE, exp_evt.pop_front());
        chk("busy_at_done", bus.o_busy, 0);
      end
      if (bus.o_cmd_error) begin
        if (exp_evt.size() == 0) unexpected("event_cmd_error", EV_ERR);
        else chk("event", EV_ERR, exp_evt.pop_front());
      end
      if (bus.o_timeout) begin
        if (exp_evt.size() == 0) unexpected("event_timeout", EV_TMO);
        else chk("event", EV_TMO, exp_evt.pop_front());
        chk("busy_at_timeout", bus.o_busy, 0);
      end
    end
  end

  // Reference model: the bytes a load puts on the wire after its opcode.
  task automatic model_load();
    logic [31:0] w;
    for (int a = 0; a < 4; a++) begin
      w = rom[a];
      for (int k = 3; k >= 0; k--) exp_tx.push_back(w[k*8 +: 8]);
      if (w == 32'hFFFF_FFFF) return;
    end
    for (int k = 0; k < 4; k++) exp_tx.push_back(8'hFF);
  endtask

  task automatic model_dump(input int mem_n);
    logic [7:0] b;
    int sec, idx;
    for (int i = 0; i < 178 + mem_n; i++) begin
      b = 8'($urandom_range(0, 255));
      dev_dump.push_back(b);
      if (i < 128) begin sec = 0; idx = i; end
      else if (i < 178) begin sec = 1; idx = i - 128; end
      else begin sec = 2; idx = (i - 178 > 255) ? 255 : i - 178; end
      exp_dump.push_back({2'(sec), 8'(idx), b});
    end
    exp_evt.push_back(EV_DEND);
    exp_mem.push_back(mem_n);
    exp_evt.push_back(EV_DONE);
    dev_dump_pending = 1'b1;
  endtask

  task automatic start_cmd(input logic [2:0] c, input int mem_n, input int echo_mode);
    logic ok;
    ok = (c <= 3'd2) ? !model_debug : (c <= 3'd4) ? model_debug : 1'b0;
    if (!ok) begin
      exp_evt.push_back(EV_ERR);
    end else begin
      exp_tx.push_back({5'd0, c});
      dev_echo_mode = echo_mode;
      if (echo_mode == 1) model_echo_err = 1'b1;
      if (echo_mode == 2) begin
        exp_evt.push_back(EV_TMO);
      end else begin
        case (c)
          3'd0: begin model_load(); exp_evt.push_back(EV_DONE); end
          3'd1, 3'd3: model_dump(mem_n);
          3'd2: begin model_debug = 1'b1; exp_evt.push_back(EV_DONE); end
          default: begin model_debug = 1'b0; exp_evt.push_back(EV_DONE); end
        endcase
      end
    end
    bus.i_cmd = c;
    bus.i_cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b0;
    chk("busy_after_issue", bus.o_busy, ok);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.o_busy && n < 8000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_cleared_in_time", bus.o_busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("echo_error", bus.o_echo_error, model_echo_err);
  endtask

  task automatic run_cmd(input logic [2:0] c, input int mem_n, input int echo_mode);
    start_cmd(c, mem_n, echo_mode);
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected $finish before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [2:0] c;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd = '0;
    for (int a = 0; a < 4; a++) rom[a] = 32'hFFFF_FFFF;

    repeat (4) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Load that halts at word 1
    rom[0] = 32'h2001_0005; rom[1] = 32'hFFFF_FFFF; rom[2] = 32'h1; rom[3] = 32'h2;
    run_cmd(3'd0, 0, 0);
    // Load without a halt word
    rom[0] = 32'd1; rom[1] = 32'd2; rom[2] = 32'd3; rom[3] = 32'd4;
    run_cmd(3'd0, 0, 0);
    // Step in IDLE is rejected
    run_cmd(3'd3, 0, 0);
    // Debug, step with 4 memory + 8 bitmap bytes, step with saturating index, end
    run_cmd(3'd2, 0, 0);
    run_cmd(3'd3, 12, 0);
    run_cmd(3'd3, 262, 0);
    run_cmd(3'd4, 0, 0);
    // Invalid opcode
    run_cmd(3'd6, 0, 0);
    // Corrupted echo on run: sticky flag through the dump
    run_cmd(3'd1, 3, 1);
    // Silent echo on debug: timeout, mode stays IDLE so step is rejected
    run_cmd(3'd2, 0, 2);
    run_cmd(3'd3, 0, 0);

    // Randomized commands, with a stray strobe while busy
    for (int it = 0; it < 10; it++) begin
      for (int a = 0; a < 4; a++)
        rom[a] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      c = 3'($urandom_range(0, 7));
      start_cmd(c, $urandom_range(0, 15), 0);
      repeat (2) @(posedge clk);
      #1;
      if (bus.o_busy) begin
        bus.i_cmd = 3'($urandom_range(0, 7));
        bus.i_cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_cmd_valid = 1'b0;
      end
      wait_idle();
    end
    if (model_debug) run_cmd(3'd4, 0, 0);

    // Reset at register byte 60 of a run dump
    sec0_seen = 0;
    start_cmd(3'd1, 4, 0);
    n = 0;
    while (sec0_seen < 61 && n < 8000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_reg_byte_60", (sec0_seen >= 61), 1);
    rst = 1'b1;
    dev_abort = 1'b1;
    @(posedge clk); #1;
    chk("outputs_after_reset", all_outs(), 0);
    exp_tx.delete(); exp_dump.delete(); exp_evt.delete(); exp_mem.delete();
    model_debug = 1'b0;
    model_echo_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    dev_abort = 1'b0;
    dev_dump_pending = 1'b0;
    dev_dump.delete();
    rom[0] = 32'hDEAD_BEEF; rom[1] = 32'h0102_0304; rom[2] = 32'hFFFF_FFFF; rom[3] = 32'h0;
    run_cmd(3'd0, 0, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("leftover_expectations", exp_tx.size() + exp_dump.size() + exp_evt.size() + exp_mem.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
